// File: rtl/imem_fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches on a pipelined
// in-order req/gnt/ack bus, buffers the returned parcels with their PC and
// fault flags, and presents the head entry to the core's IF stage.
//
// Bus handshake: a request transfers when imem_req and imem_gnt are both high
// on a rising edge. imem_adr is stable while imem_req is high. Responses come
// back in request order, one per imem_ack, no earlier than the cycle after
// their grant. imem_err and imem_q are only meaningful while imem_ack is high.
module imem_fetch_queue #(
    parameter int               XLEN        = 32,
    parameter int               PARCEL_SIZE = 32,
    parameter int               DEPTH       = 4,
    parameter logic [XLEN-1:0]  PC_INIT     = 'h200
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [XLEN-1:0]             if_nxt_pc,
    input  logic                        if_flush,
    input  logic                        if_stall,
    output logic                        if_stall_nxt_pc,
    output logic [PARCEL_SIZE-1:0]      if_parcel,
    output logic [XLEN-1:0]             if_parcel_pc,
    output logic [PARCEL_SIZE/16-1:0]   if_parcel_valid,
    output logic                        if_parcel_misaligned,
    output logic                        if_parcel_page_fault,
    output logic                        imem_req,
    output logic [XLEN-1:0]             imem_adr,
    input  logic                        imem_gnt,
    input  logic                        imem_ack,
    input  logic                        imem_err,
    input  logic [PARCEL_SIZE-1:0]      imem_q
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    // Control state
    logic [XLEN-1:0] fpc;
    logic [CW-1:0]   occ;
    logic [CW-1:0]   infl;
    logic [CW-1:0]   disc;
    logic            halt;

    // Parcel queue storage and pointers
    logic [PARCEL_SIZE-1:0] q_parcel [DEPTH];
    logic [XLEN-1:0]        q_pc     [DEPTH];
    logic [DEPTH-1:0]       q_mis;
    logic [DEPTH-1:0]       q_flt;
    logic [AW-1:0]          q_rd;
    logic [AW-1:0]          q_wr;

    // Tag FIFO: PC of each in-flight request, in issue order
    logic [XLEN-1:0]        tag_pc [DEPTH];
    logic [AW-1:0]          t_rd;
    logic [AW-1:0]          t_wr;

    logic [CW:0]            used;
    logic                   credit;
    logic                   grant;
    logic                   ack_keep;
    logic                   mis_push;
    logic                   push;
    logic                   pop;
    logic [PARCEL_SIZE-1:0] push_parcel;
    logic [XLEN-1:0]        push_pc;
    logic                   push_mis;
    logic                   push_flt;

    // Credit, request, push/pop decisions and the entry to be written
    always_comb begin
        used     = {1'b0, occ} + {1'b0, infl};
        credit   = used < DEPTH_C;
        imem_req = !rst && credit && !halt && !if_flush && (fpc[1:0] == 2'b00);
        imem_adr = fpc;
        if_stall_nxt_pc = !credit;
        grant    = imem_req && imem_gnt;
        // A response is kept only when nothing ahead of it is marked for drop
        ack_keep = imem_ack && (disc == '0) && !if_flush;
        // A misaligned PC becomes a fault entry once no live fetch is ahead of it
        mis_push = (fpc[1:0] != 2'b00) && credit && (infl == disc) && !halt && !if_flush;
        push     = ack_keep || mis_push;
        pop      = (occ != '0) && !if_stall && !if_flush;
        if (mis_push) begin
            push_parcel = '0;
            push_pc     = fpc;
            push_mis    = 1'b1;
            push_flt    = 1'b0;
        end else begin
            push_parcel = imem_err ? '0 : imem_q;
            push_pc     = tag_pc[t_rd];
            push_mis    = 1'b0;
            push_flt    = imem_err;
        end
    end

    // Fetch PC, counters, pointers and halt flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc  <= PC_INIT;
            occ  <= '0;
            infl <= '0;
            disc <= '0;
            halt <= 1'b0;
            q_rd <= '0;
            q_wr <= '0;
            t_rd <= '0;
            t_wr <= '0;
        end else if (if_flush) begin
            fpc  <= if_nxt_pc;
            halt <= 1'b0;
            occ  <= '0;
            q_rd <= '0;
            q_wr <= '0;
            // Every request still outstanding after this cycle is dropped on return
            if (imem_ack) begin
                infl <= infl - CW'(1);
                disc <= infl - CW'(1);
                t_rd <= t_rd + AW'(1);
            end else begin
                disc <= infl;
            end
        end else begin
            if (grant) begin
                fpc  <= fpc + XLEN'(4);
                t_wr <= t_wr + AW'(1);
            end
            if (imem_ack) begin
                t_rd <= t_rd + AW'(1);
                if (disc != '0) disc <= disc - CW'(1);
            end
            infl <= infl + CW'(grant) - CW'(imem_ack);
            occ  <= occ + CW'(push) - CW'(pop);
            if (push) q_wr <= q_wr + AW'(1);
            if (pop)  q_rd <= q_rd + AW'(1);
            if (mis_push || (ack_keep && imem_err)) halt <= 1'b1;
        end
    end

    // Tag capture on grant
    always_ff @(posedge clk) begin
        if (grant) tag_pc[t_wr] <= fpc;
    end

    // Queue entry write; contents are only visible through occ-gated head outputs
    always_ff @(posedge clk) begin
        if (push) begin
            q_parcel[q_wr] <= push_parcel;
            q_pc[q_wr]     <= push_pc;
            q_mis[q_wr]    <= push_mis;
            q_flt[q_wr]    <= push_flt;
        end
    end

    // Head entry presentation, all zero when the queue is empty
    always_comb begin
        if_parcel            = '0;
        if_parcel_pc         = '0;
        if_parcel_valid      = '0;
        if_parcel_misaligned = 1'b0;
        if_parcel_page_fault = 1'b0;
        if (occ != '0) begin
            if_parcel            = q_parcel[q_rd];
            if_parcel_pc         = q_pc[q_rd];
            if_parcel_valid      = '1;
            if_parcel_misaligned = q_mis[q_rd];
            if_parcel_page_fault = q_flt[q_rd];
        end
    end

endmodule
